// File: rtl/cpu_pkg.sv
// Shared encodings for the ARM-subset control path: opcodes, data-processing
// commands, ALU control values, condition codes and flag bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_UND = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_SUB = 4'b0010,
        CMD_ADD = 4'b0100,
        CMD_CMP = 4'b1010,
        CMD_ORR = 4'b1100
    } cmd_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the datapath: instruction fields and
// ALU flags in, the datapath control bundle and registered flags out.
interface control_unit_if;

    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemtoReg;
    logic        MemWrite;
    logic        PCSrc;
    logic [3:0]  Flags;

    modport master (
        output Instr, ALUFlags,
        input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
        input  MemtoReg, MemWrite, PCSrc, Flags
    );

    modport slave (
        input  Instr, ALUFlags,
        output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl,
        output MemtoReg, MemWrite, PCSrc, Flags
    );

endinterface

// File: rtl/control_unit_cond_logic.sv
// Condition evaluation against the registered NZCV flags, the split NZ/CV
// flag register and the gating of every state-changing control output.
module cond_logic
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       no_write,
    input  logic       mem_w,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] flags
);

    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       n, z, c, v;
    logic       cond_ex;
    logic [1:0] flag_write;
    logic       gate;

    assign flags = {nz_q, cv_q};
    assign n     = flags[FLAG_N];
    assign z     = flags[FLAG_Z];
    assign c     = flags[FLAG_C];
    assign v     = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign flag_write = flag_w & {2{cond_ex}};

    // Each field loads independently so ANDS/ORRS can leave C and V alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            if (flag_write[1]) nz_q <= alu_flags[3:2];
            if (flag_write[0]) cv_q <= alu_flags[1:0];
        end
    end

    assign gate      = cond_ex & reset;
    assign pc_src    = pcs & gate;
    assign reg_write = reg_w & ~no_write & gate;
    assign mem_write = mem_w & gate;

endmodule

// File: rtl/control_unit.sv
// Single-cycle control unit: main and ALU decode of the fetched instruction,
// with conditional execution and the flag register delegated to cond_logic.
module control_unit
    import cpu_pkg::*;
(
    input logic           clk,
    input logic           reset,
    control_unit_if.slave bus
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] unused_rn;

    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic [1:0] alu_control;
    logic       mem_to_reg;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       no_write;
    logic [1:0] flag_w;
    logic       pcs;

    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] flags;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign unused_rn = bus.Instr[7:4];
    assign rd        = bus.Instr[3:0];

    always_comb begin
        reg_src     = 2'b00;
        imm_src     = 2'b00;
        alu_src     = 1'b0;
        alu_control = ALU_ADD;
        mem_to_reg  = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        branch      = 1'b0;
        no_write    = 1'b0;
        flag_w      = 2'b00;
        case (op)
            OP_DP: begin
                alu_src = funct[5];
                case (funct[4:1])
                    CMD_ADD: begin
                        alu_control = ALU_ADD;
                        reg_w       = 1'b1;
                        flag_w      = {2{funct[0]}};
                    end
                    CMD_SUB: begin
                        alu_control = ALU_SUB;
                        reg_w       = 1'b1;
                        flag_w      = {2{funct[0]}};
                    end
                    CMD_AND: begin
                        alu_control = ALU_AND;
                        reg_w       = 1'b1;
                        flag_w      = {funct[0], 1'b0};
                    end
                    CMD_ORR: begin
                        alu_control = ALU_ORR;
                        reg_w       = 1'b1;
                        flag_w      = {funct[0], 1'b0};
                    end
                    // CMP without S has no defined meaning, so it is squashed.
                    CMD_CMP: begin
                        alu_control = ALU_SUB;
                        no_write    = 1'b1;
                        reg_w       = funct[0];
                        flag_w      = {2{funct[0]}};
                    end
                    default: ;
                endcase
            end
            OP_MEM: begin
                imm_src = 2'b01;
                alu_src = 1'b1;
                if (funct[0]) begin
                    reg_w      = 1'b1;
                    mem_to_reg = 1'b1;
                end else begin
                    reg_src = 2'b10;
                    mem_w   = 1'b1;
                end
            end
            OP_BR: begin
                reg_src = 2'b01;
                imm_src = 2'b10;
                alu_src = 1'b1;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcs = branch | (reg_w & (rd == 4'hF));

    cond_logic u_cond_logic (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (bus.ALUFlags),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .no_write  (no_write),
        .mem_w     (mem_w),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .flags     (flags)
    );

    assign bus.RegSrc     = reg_src;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUSrc     = alu_src;
    assign bus.ALUControl = alu_control;
    assign bus.MemtoReg   = mem_to_reg;
    assign bus.RegWrite   = reg_write;
    assign bus.MemWrite   = mem_write;
    assign bus.PCSrc      = pc_src;
    assign bus.Flags      = flags;

endmodule

// File: doc/control_unit.md
# control_unit

Single-cycle control unit for the ARM-subset processor. It decodes the fetched instruction into the datapath control bundle (RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc) plus MemWrite for data memory. It consumes the ALU's ALUFlags and holds the architectural NZCV flags register, which gates every instruction through its condition field. It sits directly upstream of the datapath and replaces the fixed control values that today's benches drive by hand.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Instr  in  20  Instr[31:12] of the current instruction: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  current ALU result flags {N,Z,C,V} = bits [3:0]
- RegSrc  out  2  [0]=1 selects R15 as RA1; [1]=1 selects Rd as RA2
- RegWrite  out  1  register-file write enable
- ImmSrc  out  2  00 imm8 rotated, 01 imm12, 10 imm24 branch
- ALUSrc  out  1  1 selects ExtImm as SrcB
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- MemtoReg  out  1  1 selects ReadData as Result
- MemWrite  out  1  data-memory write enable
- PCSrc  out  1  1 selects Result as next PC
- Flags  out  4  registered {N,Z,C,V}, for debug and the bench

## Operation
- **Main decode by Op:**
  - **00, data processing.** I=Funct[5], S=Funct[0], cmd=Funct[4:1]. RegSrc=00, ImmSrc=00, ALUSrc=I, MemtoReg=0, RegW=1, MemW=0.
  - **01, memory.** L=Funct[0]. Common: ImmSrc=01, ALUSrc=1, ALUControl=00 (offset always added).
    - STR: RegSrc=10, RegW=0, MemW=1, MemtoReg=0.
    - LDR: RegSrc=00, RegW=1, MemW=0, MemtoReg=1.
  - **10, branch.** RegSrc=01, ImmSrc=10, ALUSrc=1, ALUControl=00, Branch=1, RegW=0, MemW=0.
  - **11, undefined.** All enables 0, ALUControl=00.
- **ALU decode (Op=00):**
  - cmd 0100 ADD→00; 0010 SUB→01; 0000 AND→10; 1100 ORR→11.
  - cmd 1010 CMP→01, NoWrite=1. CMP with S=0 is undefined.
  - Any other cmd is undefined: RegW=0, FlagW=00.
- **FlagW (data processing only):**
  - FlagW[1]=S: writes N,Z.
  - FlagW[0]=S & (ADD|SUB|CMP): writes C,V.
  - ANDS/ORRS leave C,V unchanged.
- **Condition check against registered Flags:**
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V.
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V).
  - AL 1; Cond=1111 → CondEx=0.
- **Gated outputs:**
  - PCS = Branch | (RegW & Rd==1111).
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & ~NoWrite & CondEx.
  - MemWrite = MemW & CondEx.
  - FlagWrite[i] = FlagW[i] & CondEx.

## Timing
- All control outputs are combinational from Instr and the registered Flags, with zero cycle latency.
- Flags register:
  - Two fields, NZ (bits [3:2]) and CV (bits [1:0]).
  - On each rising clk edge, each field loads from ALUFlags if its FlagWrite bit is set; otherwise it holds.
  - Updated flags are visible to the next instruction only. CondEx never uses same-cycle ALUFlags.
- reset low:
  - Flags clear to 0000 immediately, without waiting for clk.
  - While reset is low, RegWrite, MemWrite and PCSrc are forced to 0.
  - RegSrc, ImmSrc, ALUSrc, ALUControl and MemtoReg keep their decoded values.
- Reset deassertion: the first edge with reset high may write flags.

## Structure
- Package cpu_pkg holds:
  - Op codes (DP, MEM, BR).
  - cmd codes (ADD, SUB, AND, ORR, CMP).
  - ALUControl encodings.
  - Cond codes EQ..AL.
  - Flag bit indices N=3, Z=2, C=1, V=0.
- Sub-module cond_logic owns the condition evaluation, the NZ/CV flags register and the output gating.
- Main and ALU decode stay in control_unit.

## Test plan
- **ORR immediate.** Instr[31:12] from 0xE3810005 (ORR R0,R1,#5) → RegWrite=1, ALUSrc=1, ImmSrc=00, RegSrc=00, ALUControl=11, MemtoReg=0, MemWrite=0, PCSrc=0.
- **Flag set then branch.**
  - 0xE0532003 (SUBS) with ALUFlags=0100 → Flags=0100 after the edge.
  - Then 0x0A000002 (BEQ) → PCSrc=1, RegSrc=01, ImmSrc=10, ALUSrc=1, RegWrite=0.
  - Then 0x1A000002 (BNE) → PCSrc=0.
- **Compare then signed branch.**
  - 0xE1510002 (CMP) with ALUFlags=1000 → RegWrite=0, ALUControl=01, Flags=1000 after the edge.
  - Then 0xBA000000 (BLT) → PCSrc=1.
- **Failed condition.** Flags=0000, 0x00911002 (ADDEQS) with ALUFlags=1111 → RegWrite=0, Flags stay 0000 after the edge.
- **Memory.**
  - 0xE5821004 (STR) → MemWrite=1, RegWrite=0, RegSrc=10, ImmSrc=01, ALUSrc=1, ALUControl=00.
  - 0xE5921004 (LDR) → MemtoReg=1, RegWrite=1.
  - 0xE592F004 (LDR into PC) → PCSrc=1.
- **Reset mid-operation.** Flags=0110, reset pulled low between edges → Flags=0000 immediately; RegWrite, MemWrite and PCSrc stay 0 while low, even for 0xE3810005.
